qn_knt_seq_ctrl: RTL and testbench
==================================

QN_KNT_SEQ_CTRL -- requirements
Module: qn_knt_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_K_TILES, default 4: accumulation blocks per output tile, minimum 1.
REQ-002 SHALL have parameter NUM_OUT_TILES, default 2: output tiles per job, minimum 1.
REQ-003 SHALL have parameter KW = $clog2(NUM_K_TILES)+1 and TW = $clog2(NUM_OUT_TILES)+1 as counter/address widths.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  job request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous job cancel.
REQ-008 sys_finish_wrap_Qn_KnT  in  1  1-cycle pulse: systolic core consumed one K block.
REQ-009 acc_done_wrap_Qn_KnT  in  1  1-cycle pulse: accumulator result stable.
REQ-010 out_ready  in  1  bridge buffer can accept the current tile.
REQ-011 en_Qn_KnT  out  1  core enable.
REQ-012 rst_n_Qn_KnT  out  1  core synchronous clear, active-low.
REQ-013 reset_acc_Qn_KnT  out  1  accumulator clear, active-high.
REQ-014 out_valid_Qn_KnT  out  1  tile result valid toward the bridge buffer.
REQ-015 addr_k  out  KW  K-block read index for the W and N input buffers.
REQ-016 tile_idx  out  TW  current output tile index.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  1-cycle pulse at job completion.

Function
REQ-019 SHALL implement the states IDLE, CLEAR, FEED, WAIT_ACC, OUTPUT and DONE, with every output registered.
REQ-020 IDLE: start=1 -> CLEAR; tile_idx and addr_k SHALL be 0.
REQ-021 CLEAR: SHALL last exactly 1 cycle with rst_n_Qn_KnT=0, reset_acc_Qn_KnT=1 and en_Qn_KnT=0, then go to FEED with addr_k=0.
REQ-022 FEED: en_Qn_KnT=1; on sys_finish_wrap_Qn_KnT, addr_k SHALL increment; when addr_k=NUM_K_TILES-1 it SHALL instead hold and go to WAIT_ACC.
REQ-023 WAIT_ACC: en_Qn_KnT=1; on acc_done_wrap_Qn_KnT -> OUTPUT.
REQ-024 OUTPUT: out_valid_Qn_KnT=1 and en_Qn_KnT=0; the transfer completes on the cycle out_valid_Qn_KnT and out_ready are both 1.
REQ-025 OUTPUT: out_valid_Qn_KnT SHALL stay high and tile_idx stable until the transfer completes.
REQ-026 On transfer: if tile_idx<NUM_OUT_TILES-1, tile_idx SHALL increment and the FSM go to CLEAR; otherwise it SHALL go to DONE.
REQ-027 DONE: done=1 for exactly 1 cycle, then IDLE with tile_idx=0 and addr_k=0.
REQ-028 start outside IDLE SHALL be ignored; start high in DONE SHALL NOT re-launch a job until IDLE is reached.
REQ-029 sys_finish_wrap_Qn_KnT outside FEED and acc_done_wrap_Qn_KnT outside WAIT_ACC SHALL be ignored.
REQ-030 acc_done_wrap_Qn_KnT arriving in FEED SHALL be ignored; the controller does not skip K blocks.
REQ-031 NUM_K_TILES=1: the first sys_finish_wrap_Qn_KnT in FEED SHALL go directly to WAIT_ACC.
REQ-032 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with no done pulse, counters zeroed and outputs at reset values.
REQ-033 abort SHALL take priority over every other transition condition in the same cycle.
REQ-034 Total latency per tile SHALL be 1 (CLEAR) + cycles to the NUM_K_TILES-th sys_finish + cycles to acc_done + handshake cycles.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, en_Qn_KnT=0, rst_n_Qn_KnT=1, reset_acc_Qn_KnT=0, out_valid_Qn_KnT=0, addr_k=0, tile_idx=0, busy=0 and done=0, regardless of clk.
REQ-036 Reset asserted mid-job SHALL abandon the job; after release, the block SHALL wait for a new start.

Verification
REQ-037 NUM_K_TILES=3, NUM_OUT_TILES=2; start; 3 sys_finish pulses, then acc_done, with out_ready=1 for each tile -> addr_k sequence 0,1,2; two CLEAR pulses; tile_idx 0 then 1; one done pulse; busy drops the cycle after done.
REQ-038 Hold out_ready=0 for 5 cycles in OUTPUT -> out_valid_Qn_KnT stays high for 6 cycles; tile_idx is unchanged throughout.
REQ-039 NUM_K_TILES=1: a single sys_finish -> WAIT_ACC; addr_k stays 0.
REQ-040 Inject a stray acc_done in FEED at addr_k=1 -> no state change; 2 more sys_finish pulses are still required.
REQ-041 abort in WAIT_ACC with start=1 in the same cycle -> IDLE next cycle; no done pulse; a new start one cycle later relaunches the job at tile_idx=0.
REQ-042 Assert rst_n=0 between clock edges during FEED -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/qn_knt_seq_ctrl.sv
// Sequencing controller for the Qn*KnT systolic tile pass: clears the core,
// feeds NUM_K_TILES K blocks, waits for the accumulator, then hands each tile to the bridge.
module qn_knt_seq_ctrl #(
  parameter int NUM_K_TILES   = 4,
  parameter int NUM_OUT_TILES = 2,
  parameter int KW            = $clog2(NUM_K_TILES) + 1,
  parameter int TW            = $clog2(NUM_OUT_TILES) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          sys_finish_wrap_Qn_KnT,
  input  logic          acc_done_wrap_Qn_KnT,
  input  logic          out_ready,
  output logic          en_Qn_KnT,
  output logic          rst_n_Qn_KnT,
  output logic          reset_acc_Qn_KnT,
  output logic          out_valid_Qn_KnT,
  output logic [KW-1:0] addr_k,
  output logic [TW-1:0] tile_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT_ACC,
    S_OUTPUT,
    S_DONE
  } state_t;

  localparam logic [KW-1:0] K_LAST = KW'(NUM_K_TILES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NUM_OUT_TILES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [KW-1:0]   addr_nxt;
  logic [TW-1:0]   tile_nxt;

  // Abort overrides every other transition; K-block pulses only count while feeding.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_k;
    tile_nxt  = tile_idx;
    if (abort) begin
      state_nxt = S_IDLE;
      addr_nxt  = '0;
      tile_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_nxt = '0;
          tile_nxt = '0;
          if (start) state_nxt = S_CLEAR;
        end
        S_CLEAR: begin
          addr_nxt  = '0;
          state_nxt = S_FEED;
        end
        S_FEED: begin
          if (sys_finish_wrap_Qn_KnT) begin
            if (addr_k == K_LAST) state_nxt = S_WAIT_ACC;
            else                  addr_nxt  = addr_k + KW'(1);
          end
        end
        S_WAIT_ACC: begin
          if (acc_done_wrap_Qn_KnT) state_nxt = S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (tile_idx < T_LAST) begin
              tile_nxt  = tile_idx + TW'(1);
              addr_nxt  = '0;
              state_nxt = S_CLEAR;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          addr_nxt  = '0;
          tile_nxt  = '0;
          state_nxt = S_IDLE;
        end
        default: begin
          addr_nxt  = '0;
          tile_nxt  = '0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are flops aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      addr_k           <= '0;
      tile_idx         <= '0;
      en_Qn_KnT        <= 1'b0;
      rst_n_Qn_KnT     <= 1'b1;
      reset_acc_Qn_KnT <= 1'b0;
      out_valid_Qn_KnT <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_nxt;
      addr_k           <= addr_nxt;
      tile_idx         <= tile_nxt;
      en_Qn_KnT        <= (state_nxt == S_FEED) || (state_nxt == S_WAIT_ACC);
      rst_n_Qn_KnT     <= (state_nxt != S_CLEAR);
      reset_acc_Qn_KnT <= (state_nxt == S_CLEAR);
      out_valid_Qn_KnT <= (state_nxt == S_OUTPUT);
      busy             <= (state_nxt != S_IDLE);
      done             <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_qn_knt_seq_ctrl.sv
// Self-checking bench for qn_knt_seq_ctrl: a job-level model checks the 3x2 instance every
// cycle, directed literal checks pin the model, and a 1x1 instance covers the single-K case.
module tb_qn_knt_seq_ctrl;

  localparam int NK = 3;
  localparam int NT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0, abort = 1'b0, sys_fin = 1'b0, acc_done = 1'b0, out_ready = 1'b0;
  logic       en, rst_core, reset_acc, out_valid, busy, done;
  logic [2:0] addr_k;
  logic [1:0] tile_idx;

  logic       start1 = 1'b0, abort1 = 1'b0, sys_fin1 = 1'b0, acc_done1 = 1'b0, out_ready1 = 1'b0;
  logic       en1, rst_core1, reset_acc1, out_valid1, busy1, done1;
  logic [0:0] addr_k1;
  logic [0:0] tile_idx1;

  int checks = 0;
  int failures = 0;
  int clear_cnt = 0, done_cnt = 0, valid_cnt = 0;

  int m_busy = 0, m_clear = 0, m_fed = 0, m_acc = 0, m_tile = 0, m_done = 0;

  always #5 clk = ~clk;

  qn_knt_seq_ctrl #(.NUM_K_TILES(NK), .NUM_OUT_TILES(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sys_finish_wrap_Qn_KnT(sys_fin), .acc_done_wrap_Qn_KnT(acc_done), .out_ready(out_ready),
    .en_Qn_KnT(en), .rst_n_Qn_KnT(rst_core), .reset_acc_Qn_KnT(reset_acc),
    .out_valid_Qn_KnT(out_valid), .addr_k(addr_k), .tile_idx(tile_idx), .busy(busy), .done(done)
  );

  qn_knt_seq_ctrl #(.NUM_K_TILES(1), .NUM_OUT_TILES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .sys_finish_wrap_Qn_KnT(sys_fin1), .acc_done_wrap_Qn_KnT(acc_done1), .out_ready(out_ready1),
    .en_Qn_KnT(en1), .rst_n_Qn_KnT(rst_core1), .reset_acc_Qn_KnT(reset_acc1),
    .out_valid_Qn_KnT(out_valid1), .addr_k(addr_k1), .tile_idx(tile_idx1), .busy(busy1), .done(done1)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Job-level model: counts K blocks consumed and tiles handed off for the current job.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || abort) begin
      m_busy = 0; m_clear = 0; m_fed = 0; m_acc = 0; m_tile = 0; m_done = 0;
    end else if (m_busy == 0) begin
      if (start) begin
        m_busy = 1; m_clear = 1; m_fed = 0; m_acc = 0; m_tile = 0;
      end
    end else if (m_done == 1) begin
      m_busy = 0; m_done = 0; m_tile = 0; m_fed = 0;
    end else if (m_clear == 1) begin
      m_clear = 0;
    end else if (m_fed < NK) begin
      if (sys_fin) m_fed = m_fed + 1;
    end else if (m_acc == 0) begin
      if (acc_done) m_acc = 1;
    end else if (out_ready) begin
      m_acc = 0;
      if (m_tile < NT - 1) begin
        m_tile = m_tile + 1; m_clear = 1; m_fed = 0;
      end else begin
        m_done = 1;
      end
    end
  end

  // Every-cycle compare of the 3x2 instance against the model.
  initial forever begin
    int clr_ph, done_ph, feed_ph, wait_ph, out_ph, exp_addr;
    @(negedge clk);
    clr_ph   = (m_busy == 1 && m_clear == 1) ? 1 : 0;
    done_ph  = (m_busy == 1 && m_done == 1) ? 1 : 0;
    feed_ph  = (m_busy == 1 && m_clear == 0 && m_done == 0 && m_fed < NK) ? 1 : 0;
    wait_ph  = (m_busy == 1 && m_clear == 0 && m_done == 0 && m_fed >= NK && m_acc == 0) ? 1 : 0;
    out_ph   = (m_busy == 1 && m_done == 0 && m_acc == 1) ? 1 : 0;
    exp_addr = (m_busy == 1) ? ((m_fed < NK - 1) ? m_fed : NK - 1) : 0;
    checkOutput("model_en", int'(en), (feed_ph | wait_ph));
    checkOutput("model_rst_core", int'(rst_core), 1 - clr_ph);
    checkOutput("model_reset_acc", int'(reset_acc), clr_ph);
    checkOutput("model_out_valid", int'(out_valid), out_ph);
    checkOutput("model_busy", int'(busy), m_busy);
    checkOutput("model_done", int'(done), done_ph);
    checkOutput("model_addr_k", int'(addr_k), exp_addr);
    checkOutput("model_tile_idx", int'(tile_idx), m_tile);
    if (rst_core == 1'b0) clear_cnt++;
    if (done == 1'b1) done_cnt++;
    if (out_valid == 1'b1) valid_cnt++;
  end

  task automatic applyStimulus(input logic st, input logic ab, input logic sf,
                               input logic ad, input logic rdy);
    @(negedge clk);
    start = st; abort = ab; sys_fin = sf; acc_done = ad; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus1(input logic st, input logic sf, input logic ad, input logic rdy);
    @(negedge clk);
    start1 = st; sys_fin1 = sf; acc_done1 = ad; out_ready1 = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, d0, v0;
    rst_n = 1'b0;
    abort1 = 1'b0;
    #22;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_rst_core", int'(rst_core), 1);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // Two full tiles with immediate handshake.
    c0 = clear_cnt; d0 = done_cnt;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clear_rst_core", int'(rst_core), 0);
    checkOutput("clear_reset_acc", int'(reset_acc), 1);
    checkOutput("clear_en", int'(en), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("feed_en", int'(en), 1);
    checkOutput("feed_addr0", int'(addr_k), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("feed_addr1", int'(addr_k), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("start_ignored_rst_core", int'(rst_core), 1);
    checkOutput("start_ignored_addr", int'(addr_k), 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("feed_addr2", int'(addr_k), 2);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wait_addr_hold", int'(addr_k), 2);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("output_valid", int'(out_valid), 1);
    checkOutput("output_en", int'(en), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tile1_idx", int'(tile_idx), 1);
    checkOutput("tile1_clear", int'(reset_acc), 1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < NK; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("done_pulse", int'(done), 1);
    checkOutput("done_busy", int'(busy), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("after_done_busy", int'(busy), 0);
    checkOutput("after_done_tile", int'(tile_idx), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("no_relaunch_busy", int'(busy), 0);
    checkOutput("clear_pulses", clear_cnt - c0, 2);
    checkOutput("done_pulses", done_cnt - d0, 1);

    // Output held off by out_ready=0 for five cycles.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < NK; i++) applyStimulus(0, 0, 1, 0, 0);
    v0 = valid_cnt;
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_tile", int'(tile_idx), 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("hold_release_valid", int'(out_valid), 0);
    checkOutput("hold_valid_cycles", valid_cnt - v0, 6);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < NK; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Stray acc_done in FEED, stray sys_finish in WAIT_ACC, then abort racing start.
    d0 = done_cnt;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("stray_acc_valid", int'(out_valid), 0);
    checkOutput("stray_acc_addr", int'(addr_k), 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("stray_acc_addr2", int'(addr_k), 2);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("stray_sys_wait_en", int'(en), 1);
    checkOutput("stray_sys_wait_valid", int'(out_valid), 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_en", int'(en), 0);
    checkOutput("abort_addr", int'(addr_k), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("relaunch_busy", int'(busy), 1);
    checkOutput("relaunch_tile", int'(tile_idx), 0);
    checkOutput("abort_no_done", done_cnt - d0, 0);
    applyStimulus(0, 1, 0, 0, 0);

    // Asynchronous reset between clock edges during FEED.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_en", int'(en), 0);
    checkOutput("async_rst_core", int'(rst_core), 1);
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_addr", int'(addr_k), 0);
    #3;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_reset_idle", int'(busy), 0);

    // Single K block, single tile instance.
    applyStimulus1(1, 0, 0, 0);
    checkOutput("k1_clear", int'(rst_core1), 0);
    applyStimulus1(0, 0, 0, 0);
    checkOutput("k1_feed_en", int'(en1), 1);
    applyStimulus1(0, 0, 1, 0);
    checkOutput("k1_stray_acc", int'(out_valid1), 0);
    applyStimulus1(0, 1, 0, 0);
    checkOutput("k1_wait_addr", int'(addr_k1), 0);
    checkOutput("k1_wait_en", int'(en1), 1);
    applyStimulus1(0, 0, 1, 0);
    checkOutput("k1_output_valid", int'(out_valid1), 1);
    applyStimulus1(0, 0, 0, 1);
    checkOutput("k1_done", int'(done1), 1);
    applyStimulus1(0, 0, 0, 0);
    checkOutput("k1_idle", int'(busy1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
